// File: rtl/rr_mux_stream_if.sv
// Stream bundle for rr_mux_stream: N producer channels in, one tagged stream out.
// slave is the multiplexer's view; master is the view of whatever drives it.
interface rr_mux_stream_if #(
    parameter int WIDTH    = 8,
    parameter int CHANNELS = 4,
    parameter int SEL_W    = $clog2(CHANNELS)
);
    logic [CHANNELS*WIDTH-1:0] in_data;
    logic [CHANNELS-1:0]       in_valid;
    logic [CHANNELS-1:0]       in_ready;
    logic [WIDTH-1:0]          out_data;
    logic [SEL_W-1:0]          out_chan;
    logic                      out_valid;
    logic                      out_ready;

    modport slave (
        input  in_data, in_valid, out_ready,
        output in_ready, out_data, out_chan, out_valid
    );

    modport master (
        output in_data, in_valid, out_ready,
        input  in_ready, out_data, out_chan, out_valid
    );
endinterface

// File: rtl/rr_mux_stream.sv
// N-channel stream multiplexer: round-robin or fixed-priority arbitration,
// manual channel force, one-entry registered output tagged with source channel.
module rr_mux_stream #(
    parameter int WIDTH    = 8,
    parameter int CHANNELS = 4,
    parameter int PRIORITY = 0,
    parameter int SEL_W    = $clog2(CHANNELS)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             force_en,
    input  logic [SEL_W-1:0] force_sel,
    rr_mux_stream_if.slave   bus
);
    localparam int unsigned NCH = CHANNELS;

    logic [WIDTH-1:0]    r_out_data;
    logic [SEL_W-1:0]    r_out_chan;
    logic                r_out_valid;
    logic [SEL_W-1:0]    r_ptr;

    logic                w_load_en;
    logic                w_any;
    logic [SEL_W-1:0]    w_gidx;
    logic [CHANNELS-1:0] w_grant;
    logic [WIDTH-1:0]    w_sel_data;
    logic                w_xfer;

    assign w_load_en = !r_out_valid || bus.out_ready;

    always_comb begin : p_grant
        int unsigned idx;
        w_any      = 1'b0;
        w_gidx     = '0;
        w_grant    = '0;
        w_sel_data = '0;
        idx        = 0;
        if (force_en) begin
            // Out-of-range force_sel matches no channel, so no grant results.
            for (int unsigned i = 0; i < NCH; i++) begin
                if (force_sel == SEL_W'(i) && bus.in_valid[i]) begin
                    w_any  = 1'b1;
                    w_gidx = SEL_W'(i);
                end
            end
        end else if (PRIORITY != 0) begin
            for (int unsigned i = 0; i < NCH; i++) begin
                if (!w_any && bus.in_valid[i]) begin
                    w_any  = 1'b1;
                    w_gidx = SEL_W'(i);
                end
            end
        end else begin
            for (int unsigned k = 0; k < NCH; k++) begin
                idx = 32'(r_ptr) + k;
                if (idx >= NCH) idx = idx - NCH;
                if (!w_any && bus.in_valid[idx]) begin
                    w_any  = 1'b1;
                    w_gidx = SEL_W'(idx);
                end
            end
        end
        for (int unsigned i = 0; i < NCH; i++) begin
            if (w_any && w_gidx == SEL_W'(i)) begin
                w_grant[i] = 1'b1;
                w_sel_data = bus.in_data[i*WIDTH +: WIDTH];
            end
        end
    end

    assign w_xfer       = w_load_en && w_any;
    assign bus.in_ready = w_load_en ? w_grant : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_data  <= '0;
            r_out_chan  <= '0;
            r_out_valid <= 1'b0;
            r_ptr       <= '0;
        end else if (w_xfer) begin
            r_out_data  <= w_sel_data;
            r_out_chan  <= w_gidx;
            r_out_valid <= 1'b1;
            if (!force_en) begin
                r_ptr <= (w_gidx == SEL_W'(CHANNELS - 1)) ? '0 : w_gidx + SEL_W'(1);
            end
        end else if (w_load_en) begin
            r_out_valid <= 1'b0;
        end
    end

    assign bus.out_data  = r_out_data;
    assign bus.out_chan  = r_out_chan;
    assign bus.out_valid = r_out_valid;
endmodule

// File: tb/tb_rr_mux_stream.sv
// Directed bench for rr_mux_stream: a round-robin 4-channel instance and a
// fixed-priority 5-channel instance (5 channels lets force_sel=5 be out of range).
module tb_rr_mux_stream;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       a_force_en = 1'b0;
    logic [1:0] a_force_sel = '0;
    logic       b_force_en = 1'b0;
    logic [2:0] b_force_sel = '0;
    int         n_checks = 0;
    int         n_pass = 0;

    always #5 clk = ~clk;

    rr_mux_stream_if #(.WIDTH(8), .CHANNELS(4)) a_if ();
    rr_mux_stream_if #(.WIDTH(8), .CHANNELS(5)) b_if ();

    rr_mux_stream #(.WIDTH(8), .CHANNELS(4), .PRIORITY(0)) u_dut_a (
        .clk(clk), .rst_n(rst_n), .force_en(a_force_en), .force_sel(a_force_sel), .bus(a_if.slave)
    );
    rr_mux_stream #(.WIDTH(8), .CHANNELS(5), .PRIORITY(1)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .force_en(b_force_en), .force_sel(b_force_sel), .bus(b_if.slave)
    );

    task automatic test_reset;
        a_if.in_valid = '0; a_if.in_data = '0; a_if.out_ready = 1'b0;
        b_if.in_valid = '0; b_if.in_data = '0; b_if.out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_checks++; if (a_if.out_valid !== 1'b0) $display("FAIL rst_valid: got %b want 0", a_if.out_valid); else n_pass++;
        n_checks++; if (a_if.out_data !== 8'h00) $display("FAIL rst_data: got %h want 00", a_if.out_data); else n_pass++;
        rst_n = 1'b1;
        a_if.in_valid = 4'b0100; a_if.in_data = {8'h00, 8'h5C, 8'h00, 8'h00};
        #1;
        n_checks++; if (a_if.in_ready !== 4'b0100) $display("FAIL rst_load_rdy: got %b want 0100", a_if.in_ready); else n_pass++;
        @(posedge clk); #1;
        a_if.in_valid = '0;
        n_checks++; if (a_if.out_valid !== 1'b1) $display("FAIL held_valid: got %b want 1", a_if.out_valid); else n_pass++;
        n_checks++; if (a_if.out_data !== 8'h5C) $display("FAIL held_data: got %h want 5c", a_if.out_data); else n_pass++;
        n_checks++; if (a_if.out_chan !== 2'd2) $display("FAIL held_chan: got %0d want 2", a_if.out_chan); else n_pass++;
        #3 rst_n = 1'b0;
        #1;
        n_checks++; if (a_if.out_valid !== 1'b0) $display("FAIL async_rst_valid: got %b want 0", a_if.out_valid); else n_pass++;
        n_checks++; if (a_if.out_data !== 8'h00) $display("FAIL async_rst_data: got %h want 00", a_if.out_data); else n_pass++;
        n_checks++; if (a_if.out_chan !== 2'd0) $display("FAIL async_rst_chan: got %0d want 0", a_if.out_chan); else n_pass++;
        a_if.in_valid = 4'b1111; a_if.in_data = {8'hA3, 8'hA2, 8'hA1, 8'hA0}; a_if.out_ready = 1'b1;
        #1;
        n_checks++; if (a_if.in_ready !== 4'b0001) $display("FAIL rst_grant0: got %b want 0001", a_if.in_ready); else n_pass++;
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    task automatic test_round_robin;
        logic [1:0] exp_chan [6] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
        logic [7:0] exp_data [6] = '{8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'hA0, 8'hA1};
        logic [3:0] exp_rdy  [6] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010};
        for (int k = 0; k < 6; k++) begin
            n_checks++; if (a_if.in_ready !== exp_rdy[k]) $display("FAIL rr_rdy[%0d]: got %b want %b", k, a_if.in_ready, exp_rdy[k]); else n_pass++;
            @(posedge clk); #1;
            n_checks++; if (a_if.out_valid !== 1'b1) $display("FAIL rr_valid[%0d]: got %b want 1", k, a_if.out_valid); else n_pass++;
            n_checks++; if (a_if.out_chan !== exp_chan[k]) $display("FAIL rr_chan[%0d]: got %0d want %0d", k, a_if.out_chan, exp_chan[k]); else n_pass++;
            n_checks++; if (a_if.out_data !== exp_data[k]) $display("FAIL rr_data[%0d]: got %h want %h", k, a_if.out_data, exp_data[k]); else n_pass++;
        end
    endtask

    // Entered with ptr=2 left behind by the round-robin sequence.
    task automatic test_sparse_wrap;
        logic [1:0] exp_chan [4] = '{2'd3, 2'd1, 2'd3, 2'd1};
        logic [3:0] exp_rdy  [4] = '{4'b1000, 4'b0010, 4'b1000, 4'b0010};
        a_if.in_valid = 4'b1010;
        #1;
        for (int k = 0; k < 4; k++) begin
            n_checks++; if (a_if.in_ready !== exp_rdy[k]) $display("FAIL sparse_rdy[%0d]: got %b want %b", k, a_if.in_ready, exp_rdy[k]); else n_pass++;
            @(posedge clk); #1;
            n_checks++; if (a_if.out_chan !== exp_chan[k]) $display("FAIL sparse_chan[%0d]: got %0d want %0d", k, a_if.out_chan, exp_chan[k]); else n_pass++;
        end
    endtask

    task automatic test_backpressure;
        a_if.in_valid = 4'b0100; a_if.in_data = {8'hD3, 8'h5C, 8'hA1, 8'hA0};
        @(posedge clk); #1;
        n_checks++; if (a_if.out_data !== 8'h5C) $display("FAIL bp_load_data: got %h want 5c", a_if.out_data); else n_pass++;
        a_if.out_ready = 1'b0; a_if.in_valid = 4'b1111;
        for (int k = 0; k < 3; k++) begin
            #1;
            n_checks++; if (a_if.in_ready !== 4'b0000) $display("FAIL bp_rdy[%0d]: got %b want 0000", k, a_if.in_ready); else n_pass++;
            @(posedge clk); #1;
            n_checks++; if (a_if.out_data !== 8'h5C) $display("FAIL bp_data[%0d]: got %h want 5c", k, a_if.out_data); else n_pass++;
            n_checks++; if (a_if.out_chan !== 2'd2) $display("FAIL bp_chan[%0d]: got %0d want 2", k, a_if.out_chan); else n_pass++;
            n_checks++; if (a_if.out_valid !== 1'b1) $display("FAIL bp_valid[%0d]: got %b want 1", k, a_if.out_valid); else n_pass++;
        end
        a_if.out_ready = 1'b1;
        #1;
        n_checks++; if (a_if.in_ready !== 4'b1000) $display("FAIL bp_resume_rdy: got %b want 1000", a_if.in_ready); else n_pass++;
        @(posedge clk); #1;
        n_checks++; if (a_if.out_data !== 8'hD3) $display("FAIL bp_resume_data: got %h want d3", a_if.out_data); else n_pass++;
        n_checks++; if (a_if.out_chan !== 2'd3) $display("FAIL bp_resume_chan: got %0d want 3", a_if.out_chan); else n_pass++;
        a_if.in_valid = '0;
        @(posedge clk); #1;
        n_checks++; if (a_if.out_valid !== 1'b0) $display("FAIL drain_valid: got %b want 0", a_if.out_valid); else n_pass++;
        n_checks++; if (a_if.out_data !== 8'hD3) $display("FAIL drain_data_hold: got %h want d3", a_if.out_data); else n_pass++;
        n_checks++; if (a_if.out_chan !== 2'd3) $display("FAIL drain_chan_hold: got %0d want 3", a_if.out_chan); else n_pass++;
    endtask

    // Entered with ptr=0; forcing must leave it there.
    task automatic test_force;
        a_force_en = 1'b1; a_force_sel = 2'd2;
        a_if.in_valid = 4'b1111; a_if.in_data = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
        #1;
        n_checks++; if (a_if.in_ready !== 4'b0100) $display("FAIL force_rdy: got %b want 0100", a_if.in_ready); else n_pass++;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            n_checks++; if (a_if.out_chan !== 2'd2) $display("FAIL force_chan[%0d]: got %0d want 2", k, a_if.out_chan); else n_pass++;
            n_checks++; if (a_if.out_data !== 8'hA2) $display("FAIL force_data[%0d]: got %h want a2", k, a_if.out_data); else n_pass++;
        end
        a_force_en = 1'b0;
        #1;
        n_checks++; if (a_if.in_ready !== 4'b0001) $display("FAIL force_ptr_rdy: got %b want 0001", a_if.in_ready); else n_pass++;
        @(posedge clk); #1;
        n_checks++; if (a_if.out_chan !== 2'd0) $display("FAIL force_ptr_chan: got %0d want 0", a_if.out_chan); else n_pass++;
        a_if.in_valid = '0;
    endtask

    task automatic test_fixed_priority;
        b_if.in_data = {8'hB4, 8'hB3, 8'hB2, 8'hB1, 8'hB0};
        b_if.in_valid = 5'b01010; b_if.out_ready = 1'b1;
        #1;
        for (int k = 0; k < 4; k++) begin
            n_checks++; if (b_if.in_ready !== 5'b00010) $display("FAIL fp_rdy[%0d]: got %b want 00010", k, b_if.in_ready); else n_pass++;
            @(posedge clk); #1;
            n_checks++; if (b_if.out_chan !== 3'd1) $display("FAIL fp_chan[%0d]: got %0d want 1", k, b_if.out_chan); else n_pass++;
            n_checks++; if (b_if.out_data !== 8'hB1) $display("FAIL fp_data[%0d]: got %h want b1", k, b_if.out_data); else n_pass++;
        end
        b_if.in_valid = 5'b01000;
        #1;
        n_checks++; if (b_if.in_ready !== 5'b01000) $display("FAIL fp_drop_rdy: got %b want 01000", b_if.in_ready); else n_pass++;
        @(posedge clk); #1;
        n_checks++; if (b_if.out_chan !== 3'd3) $display("FAIL fp_drop_chan: got %0d want 3", b_if.out_chan); else n_pass++;
        n_checks++; if (b_if.out_data !== 8'hB3) $display("FAIL fp_drop_data: got %h want b3", b_if.out_data); else n_pass++;
    endtask

    task automatic test_force_out_of_range;
        b_force_en = 1'b1; b_force_sel = 3'd5; b_if.in_valid = 5'b11111;
        #1;
        n_checks++; if (b_if.in_ready !== 5'b00000) $display("FAIL oor_rdy: got %b want 00000", b_if.in_ready); else n_pass++;
        @(posedge clk); #1;
        n_checks++; if (b_if.out_valid !== 1'b0) $display("FAIL oor_drain: got %b want 0", b_if.out_valid); else n_pass++;
        n_checks++; if (b_if.out_chan !== 3'd3) $display("FAIL oor_chan_hold: got %0d want 3", b_if.out_chan); else n_pass++;
        b_force_sel = 3'd7;
        #1;
        n_checks++; if (b_if.in_ready !== 5'b00000) $display("FAIL oor7_rdy: got %b want 00000", b_if.in_ready); else n_pass++;
        b_force_en = 1'b0; b_if.in_valid = '0;
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_sparse_wrap();
        test_backpressure();
        test_force();
        test_fixed_priority();
        test_force_out_of_range();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL watchdog: sim time %0t exceeded limit %0d", $time, 50000);
        $fatal(1);
    end
endmodule
